// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for hazard control
// Purpose: controller state enum, register-address width, zero-register id,
//          and the packed stage-control bundle with its fixed encodings.
// Ports:   none (package).
package pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_e;

   // Stage write enables followed by bubble-insert flushes.
   typedef struct packed {
      logic pc_wr;
      logic ifid_wr;
      logic idex_wr;
      logic exmem_wr;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } ctl_t;

   localparam ctl_t CTL_NORM = 7'b1111_000;
   localparam ctl_t CTL_FRZ  = 7'b0000_001;
   localparam ctl_t CTL_RST  = 7'b0000_111;
   localparam ctl_t CTL_LU   = 7'b0011_010;
   localparam ctl_t CTL_BR   = 7'b1111_110;
   localparam ctl_t CTL_JMP  = 7'b1111_100;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
// Purpose: groups hazard inputs, stage controls and status/counter outputs.
// Modports: master = pipeline side (drives hazard inputs, reads controls)
//           slave  = hazard_ctrl (reads hazard inputs, drives controls)
// Params:   CNT_W = width of stall_cycles / flush_count
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import pipe_pkg::*;

   logic                  IDEX_MemRead;
   logic [REG_ADDR_W-1:0] IDEX_rt;
   logic [REG_ADDR_W-1:0] IFID_rs;
   logic [REG_ADDR_W-1:0] IFID_rt;
   logic                  branch_taken;
   logic                  jump;
   logic                  dmem_req;
   logic                  dmem_ready;

   logic                  PC_Wr;
   logic                  IFID_Wr;
   logic                  IDEX_Wr;
   logic                  EXMEM_Wr;
   logic                  IFID_flush;
   logic                  IDEX_flush;
   logic                  MEMWB_flush;
   logic                  mem_timeout;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_count;

   modport master (
      output IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt,
             branch_taken, jump, dmem_req, dmem_ready,
      input  PC_Wr, IFID_Wr, IDEX_Wr, EXMEM_Wr,
             IFID_flush, IDEX_flush, MEMWB_flush,
             mem_timeout, stall_cycles, flush_count
   );

   modport slave (
      input  IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt,
             branch_taken, jump, dmem_req, dmem_ready,
      output PC_Wr, IFID_Wr, IDEX_Wr, EXMEM_Wr,
             IFID_flush, IDEX_flush, MEMWB_flush,
             mem_timeout, stall_cycles, flush_count
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles, sticks at all-ones.
// Ports:   clk   in  clock
//          clr   in  synchronous clear (wins over en)
//          en    in  count enable
//          count out current value
// Params:  W = counter width
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard / memory-wait controller
// Purpose: resolves load-use, branch, jump and data-memory wait hazards into
//          stage write enables and flushes; halts on data-memory timeout.
// Ports:   clk    in  clock
//          reset  in  synchronous active-high reset
//          hz     hazard_ctrl_if.slave (hazard inputs, stage controls,
//                 mem_timeout, stall_cycles, flush_count)
// Params:  MAX_WAIT = wait cycles tolerated before HALT, CNT_W = counter width
// Macro:   HAZARD_PERF_CNT_EN enables stall_cycles / flush_count counters;
//          when undefined both outputs are tied to zero.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   localparam int WC_W = $clog2(MAX_WAIT + 1);

   hz_state_e       state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_timeout_q, mem_timeout_d;
   logic            mem_stall;
   logic            load_use;
   ctl_t            run_ctl;
   ctl_t            ctl;

   assign mem_stall = hz.dmem_req && !hz.dmem_ready;
   assign load_use  = hz.IDEX_MemRead && (hz.IDEX_rt != ZERO_REG) &&
                      ((hz.IDEX_rt == hz.IFID_rs) || (hz.IDEX_rt == hz.IFID_rt));

   // Branch flushes the ID instruction, so a coincident load-use is moot.
   always_comb begin
      run_ctl = CTL_NORM;
      if (hz.branch_taken) begin
         run_ctl = CTL_BR;
      end else if (load_use) begin
         run_ctl = CTL_LU;
      end else if (hz.jump) begin
         run_ctl = CTL_JMP;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      ctl           = CTL_NORM;
      if (reset) begin
         ctl = CTL_RST;
      end else begin
         unique case (state_q)
            RUN: begin
               if (mem_stall) begin
                  ctl        = CTL_FRZ;
                  state_d    = MEM_WAIT;
                  wait_cnt_d = WC_W'(1);
               end else begin
                  ctl = run_ctl;
               end
            end
            MEM_WAIT: begin
               if (mem_stall) begin
                  ctl = CTL_FRZ;
                  if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
                     state_d       = HALT;
                     mem_timeout_d = 1'b1;
                  end else begin
                     wait_cnt_d = wait_cnt_q + WC_W'(1);
                  end
               end else begin
                  // Release cycle runs unfrozen; a branch held in IDEX acts now.
                  ctl        = run_ctl;
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end
            end
            HALT: begin
               ctl = CTL_FRZ;
            end
            default: begin
               ctl     = CTL_FRZ;
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign hz.PC_Wr       = ctl.pc_wr;
   assign hz.IFID_Wr     = ctl.ifid_wr;
   assign hz.IDEX_Wr     = ctl.idex_wr;
   assign hz.EXMEM_Wr    = ctl.exmem_wr;
   assign hz.IFID_flush  = ctl.ifid_flush;
   assign hz.IDEX_flush  = ctl.idex_flush;
   assign hz.MEMWB_flush = ctl.memwb_flush;
   assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (reset),
      .en    (!ctl.pc_wr),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (reset),
      .en    (ctl.ifid_flush || ctl.idex_flush),
      .count (flush_cnt)
   );

   assign hz.stall_cycles = stall_cnt;
   assign hz.flush_count  = flush_cnt;
`else
   assign hz.stall_cycles = '0;
   assign hz.flush_count  = '0;
`endif

endmodule
